// File: rtl/vuvxu_banked8_fu_fma_wb.sv
// Writeback stage for a fixed-latency FMA: tracks destination tags alongside the
// FMA pipeline and buffers results in a credit-protected FIFO for the consumer.
module vuvxu_banked8_fu_fma_wb #(
  parameter int STAGES = 3,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_val,
  output logic        issue_rdy,
  input  logic [7:0]  issue_vd,
  input  logic [64:0] fma_out,
  input  logic [4:0]  fma_exc,
  output logic        wb_val,
  input  logic        wb_rdy,
  output logic [7:0]  wb_vd,
  output logic [64:0] wb_data,
  output logic [4:0]  wb_exc,
  output logic [4:0]  exc_sticky,
  input  logic        exc_clr,
  output logic        busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic              accept;
  logic              push;
  logic              pop;
  logic [STAGES-1:0] tag_val;
  logic [7:0]        tag_vd [STAGES];
  logic [77:0]       mem [DEPTH];
  logic [77:0]       head;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     cnt;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign accept = issue_val & issue_rdy;
  assign push   = tag_val[STAGES-1];
  assign wb_val = (occ != '0);
  assign pop    = wb_val & wb_rdy;

  // Credits cover both in-flight and buffered ops, so a push always finds room.
  assign issue_rdy = (cnt < FULL_CNT);
  assign busy      = (cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_val <= '0;
    end else begin
      tag_val[0] <= accept;
      for (int i = 1; i < STAGES; i++) begin
        tag_val[i] <= tag_val[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_vd[0] <= issue_vd;
    for (int i = 1; i < STAGES; i++) begin
      tag_vd[i] <= tag_vd[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {tag_vd[STAGES-1], fma_out, fma_exc};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A clear coinciding with a push keeps only the newly pushed flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_sticky <= '0;
    end else if (exc_clr) begin
      exc_sticky <= push ? fma_exc : 5'b0;
    end else if (push) begin
      exc_sticky <= exc_sticky | fma_exc;
    end
  end

  assign head    = mem[rd_ptr];
  assign wb_vd   = wb_val ? head[77:70] : 8'b0;
  assign wb_data = wb_val ? head[69:5]  : 65'b0;
  assign wb_exc  = wb_val ? head[4:0]   : 5'b0;

  no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && occ == FULL_CNT));

endmodule

// File: tb/tb_vuvxu_banked8_fu_fma_wb.sv
// Directed bench for the FMA writeback stage: a table of single-op vectors with
// hand-computed results, then multi-cycle sequences checked against a small queue model.
module tb_vuvxu_banked8_fu_fma_wb;

  localparam int STAGES = 3;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_val = 1'b0;
  logic        issue_rdy;
  logic [7:0]  issue_vd = '0;
  logic [64:0] fma_out = '0;
  logic [4:0]  fma_exc = '0;
  logic        wb_val;
  logic        wb_rdy = 1'b0;
  logic [7:0]  wb_vd;
  logic [64:0] wb_data;
  logic [4:0]  wb_exc;
  logic [4:0]  exc_sticky;
  logic        exc_clr = 1'b0;
  logic        busy;

  vuvxu_banked8_fu_fma_wb #(.STAGES(STAGES), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .issue_val(issue_val), .issue_rdy(issue_rdy), .issue_vd(issue_vd),
    .fma_out(fma_out), .fma_exc(fma_exc),
    .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_vd(wb_vd), .wb_data(wb_data), .wb_exc(wb_exc),
    .exc_sticky(exc_sticky), .exc_clr(exc_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  vd;
    logic [64:0] data;
    logic [4:0]  exc;
    logic        clr;
    logic [4:0]  sticky;
  } vec_t;

  vec_t tv [5];

  int n_chk = 0;
  int n_fail = 0;
  int cycle = 0;
  int seq = 0;
  int mcnt = 0;
  int dut_acc = 0;
  int dut_pop = 0;
  logic [4:0]  msticky = '0;
  logic [77:0] mq [$];
  logic [77:0] due_map [int];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic drive_garbage();
    fma_out = {$urandom, $urandom, $urandom};
    fma_exc = 5'($urandom);
  endtask

  // One cycle of stimulus against the queue model; the bench plays the FMA unit.
  task automatic cyc(input logic iv, input logic [7:0] vd, input logic rdy, input logic clr);
    logic        acc;
    logic        pop;
    logic        push;
    logic [77:0] pe;
    logic [77:0] he;
    issue_val = iv;
    issue_vd  = vd;
    wb_rdy    = rdy;
    exc_clr   = clr;
    push = due_map.exists(cycle);
    pe = '0;
    if (push) begin
      pe = due_map[cycle];
      due_map.delete(cycle);
      fma_out = pe[69:5];
      fma_exc = pe[4:0];
    end else begin
      drive_garbage();
    end
    #1;
    he = (mq.size() != 0) ? mq[0] : 78'b0;
    chk("issue_rdy", issue_rdy, mcnt < DEPTH);
    chk("busy", busy, mcnt != 0);
    chk("wb_val", wb_val, mq.size() != 0);
    chk("wb_vd", wb_vd, he[77:70]);
    chk("wb_data", wb_data, he[69:5]);
    chk("wb_exc", wb_exc, he[4:0]);
    chk("exc_sticky", exc_sticky, msticky);
    if (issue_val && issue_rdy) dut_acc++;
    if (wb_val && wb_rdy) dut_pop++;
    acc = iv && (mcnt < DEPTH);
    pop = rdy && (mq.size() != 0);
    if (acc) begin
      seq++;
      due_map[cycle + STAGES] = {vd, vd[0], 32'(seq), 24'hC0DE00, vd, 5'(seq * 7)};
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(pe);
    if (clr) msticky = push ? pe[4:0] : 5'b0;
    else if (push) msticky = msticky | pe[4:0];
    mcnt = mcnt + int'(acc) - int'(pop);
    tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (mq.size() != 0 || due_map.size() != 0); k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    #1 chk("drained_busy", busy, 1'b0);
  endtask

  initial begin
    int base_acc;
    int base_pop;
    tv[0] = '{8'h05, 65'h1_0000_0000_0000_0001, 5'b00001, 1'b0, 5'b00001};
    tv[1] = '{8'hA3, 65'h0_DEAD_BEEF_0000_1234, 5'b00010, 1'b0, 5'b00011};
    tv[2] = '{8'hFF, 65'h1_FFFF_FFFF_FFFF_FFFF, 5'b10000, 1'b1, 5'b10000};
    tv[3] = '{8'h00, 65'h0_0000_0000_0000_0000, 5'b00000, 1'b0, 5'b10000};
    tv[4] = '{8'h7E, 65'h0_1234_5678_9ABC_DEF0, 5'b01100, 1'b0, 5'b11100};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wb_val", wb_val, 1'b0);
    chk("rst_wb_vd", wb_vd, 8'h00);
    chk("rst_wb_data", wb_data, 65'h0);
    chk("rst_wb_exc", wb_exc, 5'h0);
    chk("rst_sticky", exc_sticky, 5'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_issue_rdy", issue_rdy, 1'b1);
    @(negedge clk);

    // Single isolated ops: result visible only in cycle STAGES+1 after the accept.
    for (int i = 0; i < 5; i++) begin
      issue_val = 1'b1; issue_vd = tv[i].vd; wb_rdy = 1'b1; exc_clr = 1'b0;
      drive_garbage();
      #1 chk("t_issue_rdy", issue_rdy, 1'b1);
      tick();
      issue_val = 1'b0;
      for (int k = 1; k <= STAGES; k++) begin
        if (k == STAGES) begin
          fma_out = tv[i].data; fma_exc = tv[i].exc; exc_clr = tv[i].clr;
        end else begin
          drive_garbage();
        end
        #1;
        chk("t_wb_val_early", wb_val, 1'b0);
        chk("t_busy_inflight", busy, 1'b1);
        tick();
        exc_clr = 1'b0;
      end
      drive_garbage();
      #1;
      chk("t_wb_val", wb_val, 1'b1);
      chk("t_wb_vd", wb_vd, tv[i].vd);
      chk("t_wb_data", wb_data, tv[i].data);
      chk("t_wb_exc", wb_exc, tv[i].exc);
      chk("t_sticky", exc_sticky, tv[i].sticky);
      tick();
      #1;
      chk("t_wb_val_after", wb_val, 1'b0);
      chk("t_busy_after", busy, 1'b0);
      chk("t_wb_data_after", wb_data, 65'h0);
      @(negedge clk);
      cycle++;
    end
    msticky = tv[4].sticky;

    // exc_clr with no push zeroes the sticky flags.
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill with the consumer stalled: only DEPTH ops get credits.
    base_acc = dut_acc;
    for (int k = 0; k < 8; k++) cyc(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
    chk("fill_accepts", 32'(dut_acc - base_acc), 32'd4);
    for (int k = 0; k < 6; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    drain();

    // Continuous issue with consumer ready; each op holds a credit for STAGES+1 cycles.
    for (int k = 0; k < 20; k++) cyc(1'b1, 8'(8'h40 + k), 1'b1, 1'b0);
    drain();

    // Asynchronous reset with two ops in flight and one buffered.
    cyc(1'b1, 8'hA1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0, 1'b0);
    cyc(1'b1, 8'hA3, 1'b0, 1'b0);
    issue_val = 1'b0; wb_rdy = 1'b0;
    #1 chk("pre_rst_wb_val", wb_val, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_wb_val", wb_val, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_issue_rdy", issue_rdy, 1'b1);
    chk("mid_rst_sticky", exc_sticky, 5'h0);
    mq.delete(); due_map.delete(); mcnt = 0; msticky = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle++;
    for (int k = 0; k < 10; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Random consumer backpressure across 100 ops.
    base_acc = dut_acc;
    base_pop = dut_pop;
    for (int k = 0; k < 2000 && (dut_acc - base_acc) < 100; k++)
      cyc(1'($urandom_range(0, 3) != 0), 8'(k), 1'($urandom_range(0, 1)), 1'b0);
    chk("rand_accepts", 32'(dut_acc - base_acc), 32'd100);
    drain();
    chk("rand_pops", 32'(dut_pop - base_pop), 32'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
